// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks all 2^N_IN vectors of a one-output cone and
// records each response plus an on-set count. Optional compare-against-expected via TT_SWEEP_CHECK_EN.
module tt_sweep_ctrl #(
    parameter int N_IN   = 6,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2**N_IN-1:0]   tt_out,
`ifdef TT_SWEEP_CHECK_EN
    input  logic [2**N_IN-1:0]   exp_tt,
    output logic                 mismatch,
    output logic [N_IN-1:0]      first_bad,
`endif
    output logic [N_IN:0]        ones_cnt
);

    localparam int NV     = 2**N_IN;
    localparam int WCNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WCNT_W-1:0] SETTLE_C = WCNT_W'(SETTLE);
    localparam logic [N_IN-1:0]   LAST_VEC = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [NV-1:0]       tt_q, tt_d;
    logic [N_IN:0]       ones_q, ones_d;
`ifdef TT_SWEEP_CHECK_EN
    logic                mismatch_q, mismatch_d;
    logic [N_IN-1:0]     first_bad_q, first_bad_d;
`endif

    always_comb begin
        // NOTE: every _d starts as a copy of its flop (pulses start at 0) so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        vec_d     = vec_q;
        wcnt_d    = wcnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        tt_d      = tt_q;
        ones_d    = ones_q;
`ifdef TT_SWEEP_CHECK_EN
        mismatch_d  = mismatch_q;
        first_bad_d = first_bad_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d    = '0;
                    ones_d  = '0;
                    vec_d   = '0;
                    wcnt_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef TT_SWEEP_CHECK_EN
                    mismatch_d  = 1'b0;
                    first_bad_d = '0;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (wcnt_q != SETTLE_C) begin
                    // wcnt never exceeds SETTLE, so != is the same test as <
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end else begin
                    tt_d[vec_q] = y_in;
                    ones_d      = ones_q + (N_IN+1)'(y_in);
`ifdef TT_SWEEP_CHECK_EN
                    if (y_in != exp_tt[vec_q] && !mismatch_q) begin
                        mismatch_d  = 1'b1;
                        first_bad_d = vec_q;
                    end
`endif
                    if (vec_q == LAST_VEC) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        vec_d  = vec_q + N_IN'(1);
                        wcnt_d = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            wcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            tt_q      <= '0;
            ones_q    <= '0;
`ifdef TT_SWEEP_CHECK_EN
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            wcnt_q    <= wcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            tt_q      <= tt_d;
            ones_q    <= ones_d;
`ifdef TT_SWEEP_CHECK_EN
            mismatch_q  <= mismatch_d;
            first_bad_q <= first_bad_d;
`endif
        end
    end

    assign vec_out  = vec_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign tt_out   = tt_q;
    assign ones_cnt = ones_q;
`ifdef TT_SWEEP_CHECK_EN
    assign mismatch  = mismatch_q;
    assign first_bad = first_bad_q;
`endif

endmodule
